// File: rtl/parking_slot_allocator.sv
// Entry-gate slot allocator. It debounces the entry sensor, hands each car the
// lowest free slot, times the barrier, and releases slots on exit reports.
// It is the only writer of the occupancy vector used by the display path.
module parking_slot_allocator #(
    parameter int NUM_SLOTS = 15,
    parameter int ID_W      = 4,
    parameter int DEB_CYC   = 4,
    parameter int GATE_CYC  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_sensor,
    input  logic                 exit_valid,
    input  logic [ID_W-1:0]      exit_slot,
    output logic [NUM_SLOTS-1:0] cars,
    output logic                 full,
    output logic                 gate_open,
    output logic                 assigned_valid,
    output logic [ID_W-1:0]      assigned_slot,
    output logic                 full_reject,
    output logic                 exit_err
);

    localparam int DEB_W  = (DEB_CYC  > 1) ? $clog2(DEB_CYC)  : 1;
    localparam int GATE_W = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALLOC    = 2'd1,
        GATE     = 2'd2,
        WAIT_CLR = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic                 deb_entry, deb_entry_d;
    logic [DEB_W-1:0]     deb_cnt;
    logic                 entry_evt;
    logic [GATE_W-1:0]    gate_cnt;
    logic [NUM_SLOTS-1:0] free_hit, free_mask, alloc_oh;
    logic [ID_W-1:0]      alloc_idx;
    logic                 exit_ok;

    assign full      = &cars;
    assign entry_evt = deb_entry & ~deb_entry_d;

    // Debounce: follow the raw sensor only after DEB_CYC consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_entry   <= 1'b0;
            deb_entry_d <= 1'b0;
            deb_cnt     <= '0;
        end else begin
            deb_entry_d <= deb_entry;
            if (entry_sensor == deb_entry) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
                deb_entry <= entry_sensor;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Exit decode: a one-hot hit that only counts when the slot is occupied;
    // out-of-range indices match no bit and so fall through to an error.
    always_comb begin
        free_hit = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            free_hit[i] = exit_valid && (exit_slot == ID_W'(i));
        free_mask = free_hit & cars;
        exit_ok   = |free_mask;
    end

    // Lowest free slot from the registered vector; a slot freed this cycle is
    // still marked occupied here, so it cannot be reissued on the same edge.
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!cars[i]) alloc_idx = ID_W'(i);
        alloc_oh = ~cars & (cars + 1'b1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; entry events outside IDLE are dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (entry_evt) state_nxt = full ? WAIT_CLR : ALLOC;
            ALLOC:    state_nxt = GATE;
            GATE:     if (gate_cnt == GATE_W'(GATE_CYC - 1)) state_nxt = WAIT_CLR;
            WAIT_CLR: if (!deb_entry) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output decode: the barrier is up for the whole GATE state.
    always_comb begin
        gate_open = (state == GATE);
    end

    // Gate timer, occupancy vector and the registered one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt       <= '0;
            cars           <= '0;
            assigned_valid <= 1'b0;
            assigned_slot  <= '0;
            full_reject    <= 1'b0;
            exit_err       <= 1'b0;
        end else begin
            gate_cnt       <= (state == GATE) ? gate_cnt + 1'b1 : '0;
            cars           <= (cars & ~free_mask) | ((state == ALLOC) ? alloc_oh : '0);
            assigned_valid <= (state == ALLOC);
            if (state == ALLOC) assigned_slot <= alloc_idx;
            full_reject    <= (state == IDLE) && entry_evt && full;
            exit_err       <= exit_valid && !exit_ok;
        end
    end

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Directed bench for parking_slot_allocator: glitch rejection, allocation
// order, gate timing, full handling, exit errors, exit/alloc overlap, reset.
module tb_parking_slot_allocator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        entry_sensor;
    logic        exit_valid;
    logic [3:0]  exit_slot;
    logic [14:0] cars;
    logic        full, gate_open, assigned_valid, full_reject, exit_err;
    logic [3:0]  assigned_slot;

    int errs = 0;
    int checks = 0;

    parking_slot_allocator #(.NUM_SLOTS(15), .ID_W(4), .DEB_CYC(4), .GATE_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .entry_sensor(entry_sensor),
        .exit_valid(exit_valid), .exit_slot(exit_slot), .cars(cars),
        .full(full), .gate_open(gate_open), .assigned_valid(assigned_valid),
        .assigned_slot(assigned_slot), .full_reject(full_reject), .exit_err(exit_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold the raw sensor high for 'hold' cycles, then low for a fixed tail;
    // count the pulses seen across the whole window.
    task automatic do_entry(input int hold, output int n_av, output int n_go,
                            output int n_rej, output logic [3:0] slot,
                            output logic go_at_av);
        n_av = 0; n_go = 0; n_rej = 0; slot = 4'hF; go_at_av = 1'b0;
        entry_sensor = 1'b1;
        for (int c = 0; c < hold + 24; c++) begin
            if (c == hold) entry_sensor = 1'b0;
            tick();
            if (assigned_valid) begin
                n_av++;
                slot = assigned_slot;
                go_at_av = gate_open;
            end
            if (gate_open) n_go++;
            if (full_reject) n_rej++;
        end
    endtask

    task automatic do_exit(input logic [3:0] s);
        exit_valid = 1'b1;
        exit_slot  = s;
        tick();
        exit_valid = 1'b0;
        exit_slot  = 4'd0;
    endtask

    int         n_av, n_go, n_rej;
    logic [3:0] slot;
    logic       go_at_av;

    initial begin
        rst_n = 1'b0; entry_sensor = 1'b0; exit_valid = 1'b0; exit_slot = 4'd0;
        repeat (3) tick();
        chk("rst_cars", 32'(cars), 32'h0);
        chk("rst_gate", 32'(gate_open), 32'h0);
        chk("rst_av", 32'(assigned_valid), 32'h0);
        chk("rst_slot", 32'(assigned_slot), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_rej", 32'(full_reject), 32'h0);
        chk("rst_err", 32'(exit_err), 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Three-cycle glitch must not get through the debouncer.
        do_entry(3, n_av, n_go, n_rej, slot, go_at_av);
        chk("glitch_av", 32'(n_av), 32'd0);
        chk("glitch_gate", 32'(n_go), 32'd0);

        // First car in an empty lot.
        do_entry(10, n_av, n_go, n_rej, slot, go_at_av);
        chk("car1_av_cnt", 32'(n_av), 32'd1);
        chk("car1_slot", 32'(slot), 32'd0);
        chk("car1_gate_cyc", 32'(n_go), 32'd8);
        chk("car1_gate_with_av", 32'(go_at_av), 32'd1);
        chk("car1_cars", 32'(cars), 32'h0001);

        do_entry(10, n_av, n_go, n_rej, slot, go_at_av);
        chk("car2_slot", 32'(slot), 32'd1);
        chk("car2_cars", 32'(cars), 32'h0003);
        do_entry(10, n_av, n_go, n_rej, slot, go_at_av);
        chk("car3_slot", 32'(slot), 32'd2);
        chk("car3_cars", 32'(cars), 32'h0007);

        // Exits: valid release, then double release and out-of-range index.
        do_exit(4'd1);
        chk("exit1_cars", 32'(cars), 32'h0005);
        chk("exit1_err", 32'(exit_err), 32'h0);
        do_exit(4'd1);
        chk("exit1_again_err", 32'(exit_err), 32'h1);
        chk("exit1_again_cars", 32'(cars), 32'h0005);
        tick();
        chk("exit_err_pulse_end", 32'(exit_err), 32'h0);
        do_exit(4'd15);
        chk("exit15_err", 32'(exit_err), 32'h1);
        chk("exit15_cars", 32'(cars), 32'h0005);
        do_exit(4'd2);
        chk("exit2_cars", 32'(cars), 32'h0001);
        repeat (3) tick();

        // Exit of slot 0 in the ALLOC cycle: slot 0 is not reused this time.
        entry_sensor = 1'b1;
        repeat (5) tick();
        exit_valid = 1'b1; exit_slot = 4'd0;
        tick();
        exit_valid = 1'b0;
        chk("ovl_av", 32'(assigned_valid), 32'h1);
        chk("ovl_slot", 32'(assigned_slot), 32'd1);
        chk("ovl_gate", 32'(gate_open), 32'h1);
        chk("ovl_cars", 32'(cars), 32'h0002);
        entry_sensor = 1'b0;
        repeat (25) tick();
        chk("ovl_cars_after", 32'(cars), 32'h0002);

        // Fill all fifteen slots from empty.
        do_exit(4'd1);
        chk("empty_cars", 32'(cars), 32'h0000);
        for (int k = 0; k < 15; k++) begin
            do_entry(6, n_av, n_go, n_rej, slot, go_at_av);
            chk($sformatf("fill_slot%0d", k), 32'(slot), 32'(k));
        end
        chk("fill_cars", 32'(cars), 32'h7FFF);
        chk("fill_full", 32'(full), 32'h1);

        // Sixteenth car is refused.
        do_entry(6, n_av, n_go, n_rej, slot, go_at_av);
        chk("rej_cnt", 32'(n_rej), 32'd1);
        chk("rej_av", 32'(n_av), 32'd0);
        chk("rej_gate", 32'(n_go), 32'd0);
        chk("rej_cars", 32'(cars), 32'h7FFF);

        // Reset during the 4th gate cycle clears everything without an edge.
        do_exit(4'd0);
        chk("pre_rst_cars", 32'(cars), 32'h7FFE);
        repeat (3) tick();
        entry_sensor = 1'b1;
        repeat (9) tick();
        chk("gate4_open", 32'(gate_open), 32'h1);
        chk("gate4_cars", 32'(cars), 32'h7FFF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_gate", 32'(gate_open), 32'h0);
        chk("async_rst_cars", 32'(cars), 32'h0);
        chk("async_rst_slot", 32'(assigned_slot), 32'h0);
        entry_sensor = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("post_rst_gate", 32'(gate_open), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
